// File: rtl/nios_sys_pio_sense_pkg.sv
// Shared definitions for the nios_sys PIO slaves: register offsets and
// capture edge selections.
package nios_sys_pio_pkg;

  typedef enum logic [1:0] {
    PIO_DATA    = 2'd0,
    PIO_RSVD    = 2'd1,
    PIO_IRQMASK = 2'd2,
    PIO_EDGECAP = 2'd3
  } pio_offset_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios_sys_pio_sync_edge.sv
// Two-flop synchroniser for the PIO input bus plus a history flop and the
// edge-vector generation for the selected capture edge.
module nios_sys_pio_sync_edge
  import nios_sys_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;

  // All three flops share the reset value so release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RESET_VALUE;
      s2 <= RESET_VALUE;
      s3 <= RESET_VALUE;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_det = ~s2 & s3;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_det = s2 ^ s3;
    end else begin : g_rise
      assign edge_det = s2 & ~s3;
    end
  endgenerate

endmodule

// File: rtl/nios_sys_pio_sense.sv
// Avalon-MM input PIO: synchronised level readback, sticky W1C edge capture
// and a maskable level interrupt for the motor-side status lines.
module nios_sys_pio_sense
  import nios_sys_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr;
  pio_offset_e      offset;
  logic             unused_wdata;

  assign offset       = pio_offset_e'(address);
  assign wr           = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  nios_sys_pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .level    (level),
    .edge_det (edge_det)
  );

  always_comb begin
    clr = '0;
    if (wr && offset == PIO_EDGECAP) clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (offset)
      PIO_DATA:    rd_mux[WIDTH-1:0] = level;
      PIO_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      PIO_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:     rd_mux = '0;
    endcase
  end

  // A fresh edge overrides a simultaneous W1C so no event is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
    end else begin
      if (wr && offset == PIO_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      edgecap  <= edge_det | (edgecap & ~clr);
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_sys_pio_sense.sv
// Bench for nios_sys_pio_sense: a rising-edge instance and an any-edge
// instance share one bus, checked against a register-level model each cycle.
module tb_nios_sys_pio_sense;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_a = 8'hFF;
  logic [7:0]  in_b = 8'h00;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        irq_a;
  logic        irq_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_sys_pio_sense #(.WIDTH(8), .EDGE_TYPE(0), .RESET_VALUE(8'hFF)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  nios_sys_pio_sense #(.WIDTH(8), .EDGE_TYPE(2), .RESET_VALUE(8'h00)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b)
  );

  // Model in software-visible terms: value an input sample will show in DATA
  // (pend), what DATA shows now (vis) and one cycle earlier (prev).
  logic [7:0]  m_pend[2] = '{8'hFF, 8'h00};
  logic [7:0]  m_vis[2]  = '{8'hFF, 8'h00};
  logic [7:0]  m_prev[2] = '{8'hFF, 8'h00};
  logic [7:0]  m_cap[2]  = '{8'h00, 8'h00};
  logic [7:0]  m_mask[2] = '{8'h00, 8'h00};
  logic [31:0] m_rd[2]   = '{32'h0, 32'h0};
  localparam logic [7:0] RV[2] = '{8'hFF, 8'h00};

  always @(posedge clk or negedge reset_n) begin : model
    logic       wr;
    logic [7:0] clr, rising, falling, seen, inp;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = RV[i]; m_vis[i] = RV[i]; m_prev[i] = RV[i];
        m_cap[i] = 8'h00; m_mask[i] = 8'h00; m_rd[i] = 32'h0;
      end
    end else begin
      wr = chipselect && !write_n;
      for (int i = 0; i < 2; i++) begin
        inp     = (i == 0) ? in_a : in_b;
        clr     = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
        rising  = m_vis[i] & ~m_prev[i];
        falling = ~m_vis[i] & m_prev[i];
        seen    = (i == 0) ? rising : (rising | falling);
        case (address)
          2'd0:    m_rd[i] = {24'h0, m_vis[i]};
          2'd2:    m_rd[i] = {24'h0, m_mask[i]};
          2'd3:    m_rd[i] = {24'h0, m_cap[i]};
          default: m_rd[i] = 32'h0;
        endcase
        m_cap[i] = seen | (m_cap[i] & ~clr);
        if (wr && address == 2'd2) m_mask[i] = writedata[7:0];
        m_prev[i] = m_vis[i];
        m_vis[i]  = m_pend[i];
        m_pend[i] = inp;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_rd_a", rd_a, m_rd[0]);
    chk("model_irq_a", {31'h0, irq_a}, {31'h0, |(m_cap[0] & m_mask[0])});
    chk("model_rd_b", rd_b, m_rd[1]);
    chk("model_irq_b", {31'h0, irq_b}, {31'h0, |(m_cap[1] & m_mask[1])});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_chk(input int inst, input logic [1:0] a, input logic [31:0] exp,
                          input string name);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    chk(name, (inst == 0) ? rd_a : rd_b, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held with inputs high; reset value matches, so no capture.
    idle(3);
    chk("reset_rd_a", rd_a, 32'h0);
    chk("reset_irq_a", {31'h0, irq_a}, 32'h0);
    reset_n = 1'b1;
    idle(1);
    read_chk(0, 2'd0, 32'h0000_00FF, "data_after_reset");
    read_chk(0, 2'd3, 32'h0, "edgecap_after_reset");

    // Rising capture on bit0 with interrupt enabled.
    in_a = 8'h00;
    idle(4);
    bus_write(2'd2, 32'h01);
    in_a = 8'h01;
    idle(1); chk("rise_irq_k0", {31'h0, irq_a}, 32'h0);
    idle(1); chk("rise_irq_k1", {31'h0, irq_a}, 32'h0);
    idle(1); chk("rise_irq_k2", {31'h0, irq_a}, 32'h1);
    read_chk(0, 2'd3, 32'h01, "rise_edgecap");
    bus_write(2'd3, 32'h01);
    chk("w1c_irq_low", {31'h0, irq_a}, 32'h0);

    // Captured edge with mask off, then enable mask.
    bus_write(2'd2, 32'h00);
    in_a = 8'h09;
    idle(3);
    chk("mask_irq_off", {31'h0, irq_a}, 32'h0);
    read_chk(0, 2'd3, 32'h08, "mask_edgecap");
    bus_write(2'd2, 32'h08);
    chk("mask_irq_on", {31'h0, irq_a}, 32'h1);
    bus_write(2'd3, 32'h08);

    // W1C of bit0 lands on the same edge a new bit0 edge is captured.
    bus_write(2'd2, 32'h01);
    in_a = 8'h08; idle(3);
    in_a = 8'h09; idle(3);
    chk("coll_pre_irq", {31'h0, irq_a}, 32'h1);
    in_a = 8'h08; idle(3);
    in_a = 8'h09; idle(1);
    bus_write(2'd3, 32'h01);
    chk("coll_irq", {31'h0, irq_a}, 32'h1);
    read_chk(0, 2'd3, 32'h01, "coll_edgecap");

    // Partial clear and reserved offset.
    bus_write(2'd3, 32'hFF);
    in_a = 8'h00; idle(3);
    in_a = 8'h0F; idle(3);
    read_chk(0, 2'd3, 32'h0F, "partial_pre");
    bus_write(2'd3, 32'h05);
    read_chk(0, 2'd3, 32'h0A, "partial_post");
    bus_write(2'd1, 32'hFFFF_FFFF);
    read_chk(0, 2'd1, 32'h0, "rsvd_read");
    read_chk(0, 2'd2, 32'h01, "rsvd_mask_kept");
    read_chk(0, 2'd3, 32'h0A, "rsvd_cap_kept");
    read_chk(0, 2'd0, 32'h0F, "rsvd_data_kept");

    // Any-edge instance: capture both transitions of bit7.
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h80);
    in_b = 8'h80; idle(3);
    chk("any_rise_irq", {31'h0, irq_b}, 32'h1);
    bus_write(2'd3, 32'h80);
    chk("any_clr_irq", {31'h0, irq_b}, 32'h0);
    in_b = 8'h00; idle(3);
    chk("any_fall_irq", {31'h0, irq_b}, 32'h1);
    read_chk(1, 2'd3, 32'h80, "any_fall_edgecap");

    // Asynchronous reset mid-operation clears outputs without a clock.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd_a", rd_a, 32'h0);
    chk("async_rd_b", rd_b, 32'h0);
    chk("async_irq_b", {31'h0, irq_b}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_sys_pio_sense.md
# nios_sys_pio_sense

Avalon-MM input PIO that lets the Nios II read the motor-side status lines (tach pulse, fault, limit switches) back into software, the counterpart of the CPU-driven output PIOs that set motor speed/direction. It synchronises an external input bus, exposes its level, latches selected edges in a sticky capture register, and raises a maskable interrupt. It sits on the `nios_sys` data-master interconnect as slave `s1`.

## Interface
- `WIDTH`, 8: input port width, 1..32.
- `EDGE_TYPE`, 0: capture edge; 0 = rising, 1 = falling, 2 = any.
- `RESET_VALUE`, 0: reset value of synchroniser and history flops, WIDTH bits.

Ports:
- `clk`  in  1  single system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  word offset.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; only `[WIDTH-1:0]` used.
- `in_port`  in  WIDTH  asynchronous external inputs.
- `readdata`  out  32  registered read data, zero-extended.
- `irq`  out  1  level interrupt to the CPU.

## Operation
- Register map, word offsets:
  - 0 DATA, RO: synchronised level.
  - 1 reserved, reads 0, writes ignored.
  - 2 IRQMASK, RW: per-bit interrupt enable.
  - 3 EDGECAP, R/W1C: sticky edge flags.
- Write = `chipselect && !write_n`.
- Synchroniser: `s1 <= in_port`, `s2 <= s1`. The history flop `s3 <= s2` runs every cycle.
- DATA = `s2`.
- Edge vector, per `EDGE_TYPE`:
  - 0: `s2 & ~s3`
  - 1: `~s2 & s3`
  - 2: `s2 ^ s3`
- EDGECAP update, per bit, each cycle: `cap <= edge | (cap & ~clr)`.
  - `clr` = `writedata[i]` when writing offset 3, otherwise 0.
  - A new edge and a clear in the same cycle: the edge wins and the bit stays 1.
- IRQMASK loads `writedata[WIDTH-1:0]` on a write to offset 2.
- Writes to offsets 0 and 1 have no effect.
- `irq` = `|(cap & irqmask)`. It is combinational from registers and has no extra flop.
- Read mux selects by `address`. `readdata` is registered every clock, with no dependency on `chipselect`. Upper `32-WIDTH` bits are 0.
- Reset values:
  - `s1`, `s2`, `s3` = `RESET_VALUE`.
  - IRQMASK = 0, EDGECAP = 0, `readdata` = 0, `irq` = 0.
- A reset asserted mid-operation clears all state immediately (asynchronous). No edge is captured from the reset release itself, because `s2 == s3` at release.

## Timing
- Read latency is 1 cycle. `address` is sampled at edge N and `readdata` is valid after edge N. The fabric uses readLatency = 1 and no wait states.
- Writes complete in 1 cycle with no waitrequest.
- `in_port` level stable before edge k appears in DATA after edge k+1.
- For the matching edge type, EDGECAP sets after edge k+2, and `irq` rises in the same cycle if masked in.
- Pulses shorter than one clock may be missed. Inputs are not debounced.
- A W1C write at edge N clears the bit after edge N. `irq` falls in the same cycle unless another masked bit is set.
- A write to IRQMASK affects `irq` immediately after the write edge.

## Structure
- Shared package `nios_sys_pio_pkg` holds:
  - offsets `PIO_DATA=0`, `PIO_IRQMASK=2`, `PIO_EDGECAP=3`;
  - `EDGE_RISE/EDGE_FALL/EDGE_ANY` constants.
- One sub-module, `nios_sys_pio_sync_edge`. It contains the `s1/s2/s3` flops and the edge-vector generation, parameterised by `WIDTH`, `EDGE_TYPE` and `RESET_VALUE`.
- The top level holds the register file, read mux and irq.

## Test plan
- **Reset:** hold `reset_n=0` with `in_port=8'hFF`, then release. Required: `readdata=0`, `irq=0`. Reading offset 0 two cycles later returns `32'h000000FF` and EDGECAP reads 0.
- **Rising capture:** write IRQMASK=`8'h01`, drive `in_port` bit0 0→1 before edge k. Required: EDGECAP reads `8'h01` and `irq=1` from edge k+2. A write of `32'h01` to offset 3 clears it and `irq=0` the next cycle.
- **Mask:** set a bit3 rising edge with IRQMASK=0. Required: EDGECAP=`8'h08`, `irq` stays 0. Writing IRQMASK=`8'h08` raises `irq` the next cycle.
- **Set/clear collision:** time a W1C write of bit0 on the exact cycle a new bit0 edge is detected. Required: EDGECAP bit0 remains 1 and `irq` stays 1.
- **Partial clear and reserved offset:** start with EDGECAP=`8'h0F`, write `32'h05` to offset 3 → EDGECAP=`8'h0A`. Writing `32'hFFFFFFFF` to offset 1 changes nothing, and offset 1 reads 0.
- **EDGE_TYPE=2 instance:** toggle bit7 high then low 4 cycles apart with a W1C clear between. Required: a capture on each transition.
